// File: rtl/stage_decode_pkg.sv
// Shared MIPS opcode/funct constants and decode helpers for the decode stage.
// Imported by stage_decode and its register file.
package stage_decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  // Logical-immediate opcodes take a zero-extended imm16; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/stage_decode_grf.sv
// 32x32 register file: two bypassed read ports, one write port, reset clear.
// Optional write trace enabled by defining GRF_DISPLAY_EN.
module grf
  import stage_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_addr,
  input  logic [31:0] fwd_data
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (w_we && (w_addr != 5'd0)) begin
      regs_q[w_addr] <= w_data;
    end
  end

  // E/M forward is younger than the writeback result, so it wins.
  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] stored);
    if (a == 5'd0)                          return 32'd0;
    else if (fwd_valid && (fwd_addr == a))  return fwd_data;
    else if (w_we && (w_addr == a))         return w_data;
    else                                    return stored;
  endfunction

  always_comb begin
    rd1 = resolve(ra1, regs_q[ra1]);
    rd2 = resolve(ra2, regs_q[ra2]);
  end

`ifdef GRF_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!reset && w_we && (w_addr != 5'd0))
      $display("@%h: $%d <= %h", w_pc, w_addr, w_data);
  end
`else
  logic unused_w_pc;
  assign unused_w_pc = ^w_pc;
`endif

endmodule

// File: rtl/stage_decode.sv
// Decode stage: IF/ID register, register read, immediate extension, branch resolve, next_pc.
// Single delay slot, no flush; GRF_DISPLAY_EN enables the register-write trace in grf.
module stage_decode
  import stage_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_addr,
  input  logic [31:0] fwd_data,
  output logic [31:0] next_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic        taken
);

  logic [31:0] d_pc_q, d_instr_q;
  logic [31:0] d_pc_d, d_instr_d;

  always_comb begin
    d_pc_d    = d_pc_q;
    d_instr_d = d_instr_q;
    if (!stall) begin
      d_pc_d    = f_pc;
      d_instr_d = f_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_pc_q    <= RESET_PC;
      d_instr_q <= '0;
    end else begin
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
    end
  end

  assign d_pc    = d_pc_q;
  assign d_instr = d_instr_q;

  logic [5:0]  op, funct;
  logic [15:0] imm16;
  logic [25:0] idx26;

  assign op    = d_instr_q[31:26];
  assign funct = d_instr_q[5:0];
  assign imm16 = d_instr_q[15:0];
  assign idx26 = d_instr_q[25:0];

  grf u_grf (
    .clk       (clk),
    .reset     (reset),
    .ra1       (d_instr_q[25:21]),
    .ra2       (d_instr_q[20:16]),
    .rd1       (rs_data),
    .rd2       (rt_data),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_pc      (w_pc),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
  );

  assign imm_ext = is_zext_op(op) ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

  logic [31:0] pc_plus4, target;
  assign pc_plus4 = d_pc_q + 32'd4;

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    case (op)
      OP_BEQ: taken = (rs_data == rt_data);
      OP_BNE: taken = (rs_data != rt_data);
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], idx26, 2'b00};
      end
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) begin
          taken  = 1'b1;
          target = rs_data;
        end
      end
      default: taken = 1'b0;
    endcase
  end

  // Fetch repeats its PC while stalled, even if a jump is sitting in decode.
  assign next_pc = stall ? f_pc : (taken ? target : f_pc + 32'd4);

endmodule

// File: tb/tb_stage_decode.sv
// Directed self-checking bench for stage_decode.
module tb_stage_decode;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] f_pc, f_instr;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data, w_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] next_pc, d_pc, d_instr, rs_data, rt_data, imm_ext;
  logic        taken;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage_decode dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .f_pc      (f_pc),
    .f_instr   (f_instr),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_pc      (w_pc),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .next_pc   (next_pc),
    .d_pc      (d_pc),
    .d_instr   (d_instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm_ext   (imm_ext),
    .taken     (taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    f_pc = 32'h3000; f_instr = 32'h0;
    w_we = 1'b0; w_addr = 5'd0; w_data = 32'h0; w_pc = 32'h0;
    fwd_valid = 1'b0; fwd_addr = 5'd0; fwd_data = 32'h0;
    tick(); tick();

    // reset state
    check("rst_dpc",   d_pc, 32'h3000);
    check("rst_dinst", d_instr, 32'h0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_npc",   next_pc, 32'h3004);

    reset = 1'b0; f_instr = 32'h00A0_0021;          // addu reading rs=$5
    tick();
    check("latch_inst", d_instr, 32'h00A0_0021);
    check("rst_r5",     rs_data, 32'h0);

    // same-cycle writeback bypass on $8
    f_instr = 32'h0100_0021; f_pc = 32'h3004;
    tick();
    w_we = 1'b1; w_addr = 5'd8; w_data = 32'h1234; #1;
    check("byp", rs_data, 32'h1234);
    tick();
    w_we = 1'b0; #1;
    check("byp_st", rs_data, 32'h1234);

    // forward priority on $9
    w_we = 1'b1; w_addr = 5'd9; w_data = 32'd5; f_instr = 32'h0129_0021;
    tick();
    w_we = 1'b0; #1;
    check("r9_st", rs_data, 32'd5);
    w_we = 1'b1; w_data = 32'd6;
    fwd_valid = 1'b1; fwd_addr = 5'd9; fwd_data = 32'd7; #1;
    check("fwd_pri_rs", rs_data, 32'd7);
    check("fwd_pri_rt", rt_data, 32'd7);
    fwd_valid = 1'b0; #1;
    check("byp_pri", rs_data, 32'd6);
    f_instr = 32'h0009_0021;                         // rs=$0, rt=$9
    tick();
    w_we = 1'b0; fwd_valid = 1'b1; fwd_addr = 5'd0; fwd_data = 32'd7; #1;
    check("r0_fwd", rs_data, 32'h0);
    check("r9_new", rt_data, 32'd6);
    fwd_valid = 1'b0;

    // beq / bne
    w_we = 1'b1; w_addr = 5'd1; w_data = 32'd3;
    tick();
    w_addr = 5'd2; w_data = 32'd3; f_instr = 32'h1022_FFFF; f_pc = 32'h3004;
    tick();
    w_we = 1'b0; f_pc = 32'h3008; #1;
    check("beq_taken", {31'd0, taken}, 32'd1);
    check("beq_npc",   next_pc, 32'h3004);
    check("beq_imm",   imm_ext, 32'hFFFF_FFFF);
    w_we = 1'b1; w_addr = 5'd2; w_data = 32'd4; #1;
    check("beq_nt",     {31'd0, taken}, 32'd0);
    check("beq_nt_npc", next_pc, 32'h300C);
    f_instr = 32'h1422_FFFF; f_pc = 32'h3004;
    tick();
    w_we = 1'b0; f_pc = 32'h3008; #1;
    check("bne_taken", {31'd0, taken}, 32'd1);
    check("bne_npc",   next_pc, 32'h3004);

    // jal, then jr $31
    f_instr = 32'h0C00_0C02; f_pc = 32'h3000;
    w_we = 1'b1; w_addr = 5'd31; w_data = 32'h300C;
    tick();
    w_we = 1'b0; f_pc = 32'h3004; #1;
    check("jal_npc", next_pc, 32'h3008);
    f_instr = 32'h03E0_0008;
    tick();
    check("jr_npc",   next_pc, 32'h300C);
    check("jr_taken", {31'd0, taken}, 32'd1);

    // immediate extension
    f_instr = 32'h3400_8000;                         // ori
    tick();
    check("ori_imm",   imm_ext, 32'h0000_8000);
    check("ori_taken", {31'd0, taken}, 32'd0);
    f_instr = 32'h2400_8000;                         // addiu
    tick();
    check("addiu_imm", imm_ext, 32'hFFFF_8000);

    // branch target wraps past 2^32
    f_instr = 32'h1000_0001; f_pc = 32'hFFFF_FFFC;
    tick();
    f_pc = 32'h3000; #1;
    check("br_wrap", next_pc, 32'h0000_0004);

    // unknown opcode behaves as nop
    f_instr = 32'hFC00_0000; f_pc = 32'h3010;
    tick();
    check("unk_taken", {31'd0, taken}, 32'd0);
    check("unk_npc",   next_pc, 32'h3014);

    // stall holds decode but not the register write
    f_instr = 32'h0100_0021; f_pc = 32'h3010;
    tick();
    stall = 1'b1; f_instr = 32'h03E0_0008; f_pc = 32'h3020;
    w_we = 1'b1; w_addr = 5'd10; w_data = 32'hABCD; #1;
    check("stall_npc", next_pc, 32'h3020);
    tick();
    w_we = 1'b0; #1;
    check("stall_hold1", d_instr, 32'h0100_0021);
    tick();
    check("stall_hold2", d_instr, 32'h0100_0021);
    check("stall_dpc",   d_pc, 32'h3010);
    stall = 1'b0; f_instr = 32'h0140_0021;
    tick();
    check("stall_wr", rs_data, 32'hABCD);

    // mid-run reset dominates stall and w_we
    f_instr = 32'h03E0_0008;
    tick();
    check("pre_rst_taken", {31'd0, taken}, 32'd1);
    reset = 1'b1; stall = 1'b1; f_pc = 32'h3100;
    w_we = 1'b1; w_addr = 5'd8; w_data = 32'h55;
    tick();
    reset = 1'b0; stall = 1'b0; w_we = 1'b0; #1;
    check("mrst_taken", {31'd0, taken}, 32'd0);
    check("mrst_rs",    rs_data, 32'h0);
    check("mrst_rt",    rt_data, 32'h0);
    check("mrst_npc",   next_pc, 32'h3104);
    check("mrst_dpc",   d_pc, 32'h3000);
    f_instr = 32'h0100_0021;
    tick();
    check("mrst_r8", rs_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
